core_insn_queue: RTL and testbench
==================================

Name: core_insn_queue

Overview:
- Halfword instruction queue directly downstream of core_fetch; consumes the hi/lo instruction pair fetch presents each cycle.
- Splits each pair into individual 16-bit instructions, buffers them in a circular FIFO, and issues one instruction plus PC per cycle to decode via a valid/ready handshake.
- Generates the stall that holds fetch when it cannot accept a full pair; discards all contents on flush (branch or prefetch flush).

Parameters:
- DEPTH_ORDER, 3, log2 of queue capacity in halfword entries (DEPTH = 2**DEPTH_ORDER, minimum 2 i.e. DEPTH_ORDER>=1).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  drop all queued and incoming instructions (from fetch flush output).
- in_valid  input  1  fetch presents a valid pair this cycle.
- in_lo_skip  input  1  low half of pair is not architecturally live (odd branch target); only hi is enqueued.
- in_lo_insn  input  16  lower-address instruction (issued first).
- in_hi_insn  input  16  upper-address instruction.
- in_lo_pc  input  31  halfword PC of in_lo_insn.
- in_hi_pc  input  31  halfword PC of in_hi_insn.
- stall  output  1  to fetch: pair not accepted this cycle, hold it.
- out_valid  output  1  out_insn/out_pc hold a live instruction.
- out_insn  output  16  head instruction.
- out_pc  output  31  head instruction halfword PC.
- out_ready  input  1  decode consumes head when out_valid && out_ready.

Behaviour:
- Storage: DEPTH entries of {insn[15:0], pc[30:0]}; rd_ptr, wr_ptr DEPTH_ORDER bits, wrap naturally modulo DEPTH; count DEPTH_ORDER+1 bits, range 0..DEPTH.
- Reset (rst=1 at posedge): rd_ptr=0, wr_ptr=0, count=0. Outputs: out_valid=0, stall=0. Entry contents are not reset; out_insn/out_pc are don't-care while out_valid=0.
- stall = (count >= DEPTH-1). Combinational from registered count only; it does not depend on same-cycle out_ready.
- Push accepted when in_valid && !stall && !flush:
  - in_lo_skip=0: write lo at wr_ptr and hi at wr_ptr+1; wr_ptr += 2; pushes = 2.
  - in_lo_skip=1: write hi at wr_ptr; wr_ptr += 1; pushes = 1.
- in_valid while stall=1: nothing written. Fetch holds the pair and re-presents it.
- out_valid = (count != 0) && !flush. out_insn/out_pc = entry[rd_ptr], combinational read.
- Pop when out_valid && out_ready: rd_ptr += 1; pops = 1.
- count_next = count + pushes - pops; simultaneous push and pop is legal in the same cycle.
- Latency: an entry pushed in cycle N is first visible at out in cycle N+1. There is no input-to-output bypass, including when the queue is empty.
- flush=1: overrides push and pop. Next cycle rd_ptr=0, wr_ptr=0, count=0. out_valid=0 during the flush cycle. The pair presented with flush is discarded.
- Order: lo always issues before hi of the same pair. Pairs issue in arrival order.
- Full boundary: the largest legal count is DEPTH. A 2-push from count=DEPTH-2 reaches DEPTH; stall then stays high until count <= DEPTH-2.
- Empty boundary: count=0 gives out_valid=0; out_ready is ignored.
- rst has priority over flush and all other inputs.
- rst asserted mid-operation: same result as power-on reset in the following cycle; in-flight pair is lost.

Test Plan:
- Reset, then in_valid=1, lo=16'h1111 pc=31'h100, hi=16'h2222 pc=31'h101, out_ready=1 -> cycle+1 out 1111/100, cycle+2 out 2222/101, cycle+3 out_valid=0.
- in_lo_skip=1, hi=16'hABCD pc=31'h201 -> only ABCD/201 issued; lo never appears; count peaks at 1.
- out_ready=0, push pairs each cycle at DEPTH=8 -> stall rises once count=7 or 8 (after 4th pair, count=8); 5th pair held; release out_ready -> stall drops at count=6, held pair enqueued, all 10 instructions issue in order.
- Steady state, push pair and pop every cycle across pointer wrap (>=20 pairs) -> PCs strictly increasing by 1, no loss or duplication.
- Queue holding 5 entries plus concurrent in_valid, assert flush -> out_valid=0 that cycle, count=0 next cycle; next pair issues from rd_ptr=0.
- Assert rst with count=6 and in_valid=1 -> next cycle out_valid=0, stall=0; subsequent pushes behave as after power-on.

Source files
------------

// File: rtl/core_insn_queue.sv
// Halfword instruction queue between fetch and decode: splits each fetched
// hi/lo pair into 16-bit entries, buffers them circularly and issues one per cycle.
module core_insn_queue #(
    parameter int DEPTH_ORDER = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    input  logic        in_lo_skip,
    input  logic [15:0] in_lo_insn,
    input  logic [15:0] in_hi_insn,
    input  logic [30:0] in_lo_pc,
    input  logic [30:0] in_hi_pc,
    output logic        stall,
    output logic        out_valid,
    output logic [15:0] out_insn,
    output logic [30:0] out_pc,
    input  logic        out_ready
);

    localparam int DEPTH = 1 << DEPTH_ORDER;
    localparam int CNT_W = DEPTH_ORDER + 1;
    localparam logic [CNT_W-1:0]       STALL_LEVEL = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]       CNT_ZERO    = CNT_W'(32'd0);
    localparam logic [CNT_W-1:0]       CNT_ONE     = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0]       CNT_TWO     = CNT_W'(32'd2);
    localparam logic [DEPTH_ORDER-1:0] PTR_ZERO    = DEPTH_ORDER'(32'd0);
    localparam logic [DEPTH_ORDER-1:0] PTR_ONE     = DEPTH_ORDER'(32'd1);

    logic [15:0]            insn_mem_r [DEPTH];
    logic [30:0]            pc_mem_r   [DEPTH];
    logic [DEPTH_ORDER-1:0] rd_ptr_r;
    logic [DEPTH_ORDER-1:0] wr_ptr_r;
    logic [CNT_W-1:0]       count_r;

    logic                   push_s;
    logic                   pop_s;
    logic [CNT_W-1:0]       push_cnt_s;
    logic [CNT_W-1:0]       pop_cnt_s;
    logic [CNT_W-1:0]       count_next_s;
    logic [DEPTH_ORDER-1:0] wr_ptr_inc_s;
    logic [DEPTH_ORDER-1:0] hi_idx_s;
    logic [DEPTH_ORDER-1:0] wr_ptr_next_s;
    logic [DEPTH_ORDER-1:0] rd_ptr_next_s;

    // Handshake decode; stall looks only at the registered count so fetch never sees a ready loop.
    always_comb begin
        stall     = (count_r >= STALL_LEVEL);
        out_valid = (count_r != CNT_ZERO) && !flush;
        push_s    = in_valid && !stall && !flush;
        pop_s     = out_valid && out_ready;
    end

    // Occupancy and pointer arithmetic; pointers wrap naturally at DEPTH.
    always_comb begin
        push_cnt_s = CNT_ZERO;
        pop_cnt_s  = CNT_ZERO;
        if (push_s) begin
            if (in_lo_skip) begin
                push_cnt_s = CNT_ONE;
            end else begin
                push_cnt_s = CNT_TWO;
            end
        end else begin
            push_cnt_s = CNT_ZERO;
        end
        if (pop_s) begin
            pop_cnt_s = CNT_ONE;
        end else begin
            pop_cnt_s = CNT_ZERO;
        end
        count_next_s  = count_r + push_cnt_s - pop_cnt_s;
        wr_ptr_inc_s  = wr_ptr_r + PTR_ONE;
        hi_idx_s      = in_lo_skip ? wr_ptr_r : wr_ptr_inc_s;
        wr_ptr_next_s = wr_ptr_r + push_cnt_s[DEPTH_ORDER-1:0];
        rd_ptr_next_s = rd_ptr_r + pop_cnt_s[DEPTH_ORDER-1:0];
    end

    // Pointer and occupancy registers; reset outranks flush, flush outranks traffic.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r <= PTR_ZERO;
            wr_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else if (flush) begin
            rd_ptr_r <= PTR_ZERO;
            wr_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            rd_ptr_r <= rd_ptr_next_s;
            wr_ptr_r <= wr_ptr_next_s;
            count_r  <= count_next_s;
        end
    end

    // Entry storage is left unreset; the low half lands first so it issues first.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            if (!in_lo_skip) begin
                insn_mem_r[wr_ptr_r] <= in_lo_insn;
                pc_mem_r[wr_ptr_r]   <= in_lo_pc;
            end
            insn_mem_r[hi_idx_s] <= in_hi_insn;
            pc_mem_r[hi_idx_s]   <= in_hi_pc;
        end
    end

    // Head entry, read straight from storage with no input bypass.
    always_comb begin
        out_insn = insn_mem_r[rd_ptr_r];
        out_pc   = pc_mem_r[rd_ptr_r];
    end

endmodule

// File: tb/tb_core_insn_queue.sv
// Scoreboard bench for core_insn_queue: driver queues expected entries, a
// negedge monitor pops and compares them against what the queue issues.
module tb_core_insn_queue;

    localparam int DEPTH_ORDER = 3;
    localparam int DEPTH = 1 << DEPTH_ORDER;

    typedef struct packed {
        logic [15:0] insn;
        logic [30:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_lo_skip = 1'b0;
    logic [15:0] in_lo_insn = 16'h0;
    logic [15:0] in_hi_insn = 16'h0;
    logic [30:0] in_lo_pc = 31'h0;
    logic [30:0] in_hi_pc = 31'h0;
    logic        stall;
    logic        out_valid;
    logic [15:0] out_insn;
    logic [30:0] out_pc;
    logic        out_ready = 1'b0;

    core_insn_queue #(.DEPTH_ORDER(DEPTH_ORDER)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_lo_skip(in_lo_skip),
        .in_lo_insn(in_lo_insn), .in_hi_insn(in_hi_insn),
        .in_lo_pc(in_lo_pc), .in_hi_pc(in_hi_pc),
        .stall(stall), .out_valid(out_valid),
        .out_insn(out_insn), .out_pc(out_pc), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    ent_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    bit   mon_en = 1'b0;

    // what the driver decided about the inputs currently presented
    bit          p_acc = 1'b0;
    bit          p_clr = 1'b0;
    bit          p_skip = 1'b0;
    logic [15:0] p_lo, p_hi;
    logic [30:0] p_lo_pc, p_hi_pc;
    logic [30:0] next_pc = 31'h300;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // monitor: expected outputs follow from the model queue alone
    always @(negedge clk) begin
        if (mon_en) begin
            bit exp_v;
            bit exp_st;
            exp_v  = (exp_q.size() != 0) && !flush;
            exp_st = (exp_q.size() >= DEPTH - 1);
            chk("stall", {31'd0, stall}, {31'd0, exp_st});
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
            if (exp_v && out_valid) begin
                chk("out_insn", {16'd0, out_insn}, {16'd0, exp_q[0].insn});
                chk("out_pc", {1'b0, out_pc}, {1'b0, exp_q[0].pc});
            end
            if (exp_v && out_ready) void'(exp_q.pop_front());
        end
    end

    // one clock: commit the previous cycle's decision, then present new inputs
    task automatic cycle(input logic v, input logic sk, input logic [15:0] lo, input logic [15:0] hi,
                         input logic [30:0] lpc, input logic rdy, input logic fl, input logic r);
        @(posedge clk);
        if (p_clr) exp_q.delete();
        else if (p_acc) begin
            if (!p_skip) exp_q.push_back('{insn: p_lo, pc: p_lo_pc});
            exp_q.push_back('{insn: p_hi, pc: p_hi_pc});
        end
        #1;
        in_valid = v; in_lo_skip = sk; in_lo_insn = lo; in_hi_insn = hi;
        in_lo_pc = lpc; in_hi_pc = lpc + 31'd1; out_ready = rdy; flush = fl; rst = r;
        p_clr = fl || r;
        p_acc = v && !fl && !r && (exp_q.size() < DEPTH - 1);
        p_skip = sk; p_lo = lo; p_hi = hi; p_lo_pc = lpc; p_hi_pc = lpc + 31'd1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0, 16'h0, 31'h0, rdy, 1'b0, 1'b0);
    endtask

    // present a pair until accepted, like fetch holding under stall
    task automatic send_pair(input logic sk, input logic [15:0] lo, input logic [15:0] hi,
                             input logic [30:0] lpc, input logic rdy);
        int tries;
        tries = 0;
        do begin
            cycle(1'b1, sk, lo, hi, lpc, rdy, 1'b0, 1'b0);
            tries++;
        end while (!p_acc && tries < 64);
        if (!p_acc) begin
            checks++;
            $display("FAIL send_pair_timeout: pair pc %0h never accepted", lpc);
        end
    endtask

    task automatic seq_pair(input logic rdy);
        send_pair(1'b0, {4'hA, next_pc[11:0]}, {4'hB, next_pc[11:0]}, next_pc, rdy);
        next_pc = next_pc + 31'd2;
    endtask

    initial begin
        // reset
        cycle(1'b0, 1'b0, 16'h0, 16'h0, 31'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 16'h0, 16'h0, 31'h0, 1'b0, 1'b0, 1'b1);
        mon_en = 1'b1;
        idle(2, 1'b1);

        // basic pair, then skipped low half
        send_pair(1'b0, 16'h1111, 16'h2222, 31'h100, 1'b1);
        idle(4, 1'b1);
        send_pair(1'b1, 16'hDEAD, 16'hABCD, 31'h200, 1'b1);
        idle(3, 1'b1);

        // fill to DEPTH with decode stalled, hold 5th pair, then release
        for (int i = 0; i < 4; i++) seq_pair(1'b0);
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 1'b0, {4'hA, next_pc[11:0]}, {4'hB, next_pc[11:0]}, next_pc, 1'b0, 1'b0, 1'b0);
        seq_pair(1'b1);
        idle(12, 1'b1);

        // steady streaming across pointer wrap
        for (int i = 0; i < 24; i++) seq_pair(1'b1);
        idle(12, 1'b1);

        // flush with 5 entries queued and a pair incoming
        seq_pair(1'b0);
        seq_pair(1'b0);
        send_pair(1'b1, 16'h0, 16'h5555, 31'h500, 1'b0);
        cycle(1'b1, 1'b0, 16'h6666, 16'h7777, 31'h600, 1'b1, 1'b1, 1'b0);
        seq_pair(1'b1);
        idle(4, 1'b1);

        // reset mid-operation with count=6 and a pair incoming
        for (int i = 0; i < 3; i++) seq_pair(1'b0);
        cycle(1'b1, 1'b0, 16'h8888, 16'h9999, 31'h700, 1'b1, 1'b0, 1'b1);
        seq_pair(1'b1);
        idle(4, 1'b1);

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  16'($urandom), 16'($urandom), next_pc,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 30) == 0,
                  $urandom_range(0, 80) == 0);
            next_pc = next_pc + 31'd2;
        end
        idle(3 * DEPTH, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
